mailbox_channel: RTL and testbench

- Flow-controlled byte mailbox between two processors (side 1, side 2) on the OUTBUS/INBUS register buses.
- Each direction has a FIFO, a status register, a control register and a level interrupt.
- Replaces the single unflagged exchange register, so senders cannot silently overwrite unread data.
- Sits on the bus as a peer of other memory-mapped devices, one register window per side.

---
 rtl/mailbox_pkg.sv | 23 ++
 rtl/mailbox_fifo.sv | 46 ++++
 rtl/mailbox_channel.sv | 124 ++++++++++++
 tb/tb_mailbox_channel.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mailbox_pkg.sv
// Shared definitions for the two-way byte mailbox: register offsets, STATUS/CONTROL bit positions.
package mailbox_pkg;

  localparam logic [7:0] MB_DATA   = 8'd0;
  localparam logic [7:0] MB_STATUS = 8'd1;
  localparam logic [7:0] MB_CTRL   = 8'd2;

  localparam int ST_RX_AVAIL   = 0;
  localparam int ST_TX_FULL    = 1;
  localparam int ST_TX_EMPTY   = 2;
  localparam int ST_RX_CNT_LSB = 3;
  localparam int ST_OVF        = 6;
  localparam int ST_UNF        = 7;

  localparam int CTRL_IE_RX = 0;
  localparam int CTRL_IE_TX = 1;

  // STATUS only has three bits for the count; deeper FIFOs report 7 when fuller.
  function automatic logic [2:0] sat_count(input logic [4:0] c);
    return (c > 5'd7) ? 3'd7 : c[2:0];
  endfunction

endpackage

// File: rtl/mailbox_fifo.sv
// Byte FIFO for one mailbox direction. Over/underflowing requests are ignored here;
// the caller flags them. Full/empty decisions use the pre-edge count.
module mailbox_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               wdata,
  output logic [7:0]               rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push_ok, pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/mailbox_channel.sv
// Flow-controlled byte mailbox between two bus masters: per side a DATA/STATUS/CONTROL
// window, sticky ovf/unf flags and a registered level interrupt.
module mailbox_channel
  import mailbox_pkg::*;
#(
  parameter logic [7:0] DEVADDR1 = 8'h00,
  parameter logic [7:0] DEVADDR2 = 8'h00,
  parameter int         DEPTH    = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] OUTBUS_ADDR1,
  input  logic [7:0] OUTBUS_DATA1,
  input  logic       OUTBUS_WE1,
  input  logic [7:0] INBUS_ADDR1,
  output logic [7:0] INBUS_DATA1,
  input  logic       INBUS_RE1,
  output logic       IRQ1,
  input  logic [7:0] OUTBUS_ADDR2,
  input  logic [7:0] OUTBUS_DATA2,
  input  logic       OUTBUS_WE2,
  input  logic [7:0] INBUS_ADDR2,
  output logic [7:0] INBUS_DATA2,
  input  logic       INBUS_RE2,
  output logic       IRQ2
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [7:0]    wr_addr [2];
  logic [7:0]    wr_data [2];
  logic [7:0]    rd_addr [2];
  logic [1:0]    wr_en, rd_en;
  logic [1:0]    push, pop, f_full, f_empty;
  logic [7:0]    f_rdata [2];
  logic [CW-1:0] f_count [2];
  logic [7:0]    rd_data_q [2];
  logic [1:0]    irq_q;

  assign wr_addr[0] = OUTBUS_ADDR1;
  assign wr_addr[1] = OUTBUS_ADDR2;
  assign wr_data[0] = OUTBUS_DATA1;
  assign wr_data[1] = OUTBUS_DATA2;
  assign rd_addr[0] = INBUS_ADDR1;
  assign rd_addr[1] = INBUS_ADDR2;
  assign wr_en      = {OUTBUS_WE2, OUTBUS_WE1};
  assign rd_en      = {INBUS_RE2, INBUS_RE1};

  assign INBUS_DATA1 = rd_data_q[0];
  assign INBUS_DATA2 = rd_data_q[1];
  assign IRQ1        = irq_q[0];
  assign IRQ2        = irq_q[1];

  // FIFO s carries bytes written by side s; it is popped by the other side R.
  for (genvar s = 0; s < 2; s++) begin : g_side
    localparam int         R    = 1 - s;
    localparam logic [7:0] BASE = (s == 0) ? DEVADDR1 : DEVADDR2;

    logic       wr_dat, wr_st, wr_ctl, rd_dat, rd_st, rd_ctl;
    logic [1:0] ctrl;
    logic       ovf, unf, irq;
    logic [7:0] status, rd_mux, rd_q;

    assign wr_dat = wr_en[s] && (wr_addr[s] == BASE + MB_DATA);
    assign wr_st  = wr_en[s] && (wr_addr[s] == BASE + MB_STATUS);
    assign wr_ctl = wr_en[s] && (wr_addr[s] == BASE + MB_CTRL);
    assign rd_dat = rd_en[s] && (rd_addr[s] == BASE + MB_DATA);
    assign rd_st  = rd_en[s] && (rd_addr[s] == BASE + MB_STATUS);
    assign rd_ctl = rd_en[s] && (rd_addr[s] == BASE + MB_CTRL);

    assign push[s] = wr_dat;
    assign pop[R]  = rd_dat;

    mailbox_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push[s]),
      .pop     (pop[s]),
      .wdata   (wr_data[s]),
      .rdata   (f_rdata[s]),
      .full    (f_full[s]),
      .empty   (f_empty[s]),
      .count   (f_count[s])
    );

    always_comb begin
      status                          = '0;
      status[ST_RX_AVAIL]             = !f_empty[R];
      status[ST_TX_FULL]              = f_full[s];
      status[ST_TX_EMPTY]             = f_empty[s];
      status[ST_RX_CNT_LSB +: 3]      = sat_count(5'(f_count[R]));
      status[ST_OVF]                  = ovf;
      status[ST_UNF]                  = unf;
    end

    always_comb begin
      rd_mux = '0;
      if (rd_dat)      rd_mux = f_empty[R] ? 8'h00 : f_rdata[R];
      else if (rd_st)  rd_mux = status;
      else if (rd_ctl) rd_mux = {6'b0, ctrl};
    end

    // A new overflow/underflow event wins over a same-cycle W1C.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        rd_q <= '0;
        ctrl <= '0;
        ovf  <= 1'b0;
        unf  <= 1'b0;
        irq  <= 1'b0;
      end else begin
        rd_q <= rd_mux;
        if (wr_ctl) ctrl <= wr_data[s][1:0];
        ovf <= (wr_dat && f_full[s]) || (ovf && !(wr_st && wr_data[s][ST_OVF]));
        unf <= (rd_dat && f_empty[R]) || (unf && !(wr_st && wr_data[s][ST_UNF]));
        irq <= (ctrl[CTRL_IE_RX] && !f_empty[R]) || (ctrl[CTRL_IE_TX] && f_empty[s]);
      end
    end

    assign rd_data_q[s] = rd_q;
    assign irq_q[s]     = irq;
  end

endmodule

// File: tb/tb_mailbox_channel.sv
// Scoreboard bench for mailbox_channel: reads queue their expected byte, a monitor compares
// the registered read data one cycle later.
module tb_mailbox_channel;
  import mailbox_pkg::*;

  localparam logic [7:0] A1 = 8'h10;
  localparam logic [7:0] A2 = 8'h20;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] OUTBUS_ADDR1 = '0, OUTBUS_DATA1 = '0, INBUS_ADDR1 = '0;
  logic [7:0] OUTBUS_ADDR2 = '0, OUTBUS_DATA2 = '0, INBUS_ADDR2 = '0;
  logic       OUTBUS_WE1 = 1'b0, INBUS_RE1 = 1'b0, OUTBUS_WE2 = 1'b0, INBUS_RE2 = 1'b0;
  logic [7:0] INBUS_DATA1, INBUS_DATA2;
  logic       IRQ1, IRQ2;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [7:0] q1v[$], q2v[$];
  string      q1n[$], q2n[$];

  mailbox_channel #(.DEVADDR1(A1), .DEVADDR2(A2), .DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .OUTBUS_ADDR1(OUTBUS_ADDR1), .OUTBUS_DATA1(OUTBUS_DATA1), .OUTBUS_WE1(OUTBUS_WE1),
    .INBUS_ADDR1(INBUS_ADDR1), .INBUS_DATA1(INBUS_DATA1), .INBUS_RE1(INBUS_RE1), .IRQ1(IRQ1),
    .OUTBUS_ADDR2(OUTBUS_ADDR2), .OUTBUS_DATA2(OUTBUS_DATA2), .OUTBUS_WE2(OUTBUS_WE2),
    .INBUS_ADDR2(INBUS_ADDR2), .INBUS_DATA2(INBUS_DATA2), .INBUS_RE2(INBUS_RE2), .IRQ2(IRQ2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %02h expected %02h", name, act, exp);
  endtask

  task automatic set_wr(input int side, input logic [7:0] off, input logic [7:0] d);
    if (side == 1) begin
      OUTBUS_WE1 = 1'b1; OUTBUS_ADDR1 = A1 + off; OUTBUS_DATA1 = d;
    end else begin
      OUTBUS_WE2 = 1'b1; OUTBUS_ADDR2 = A2 + off; OUTBUS_DATA2 = d;
    end
  endtask

  task automatic set_rd(input int side, input logic [7:0] off, input logic [7:0] exp,
                        input string name);
    if (side == 1) begin
      INBUS_RE1 = 1'b1; INBUS_ADDR1 = A1 + off; q1v.push_back(exp); q1n.push_back(name);
    end else begin
      INBUS_RE2 = 1'b1; INBUS_ADDR2 = A2 + off; q2v.push_back(exp); q2n.push_back(name);
    end
  endtask

  task automatic step();
    @(negedge clk);
    OUTBUS_WE1 = 1'b0; OUTBUS_ADDR1 = '0; OUTBUS_DATA1 = '0; INBUS_RE1 = 1'b0; INBUS_ADDR1 = '0;
    OUTBUS_WE2 = 1'b0; OUTBUS_ADDR2 = '0; OUTBUS_DATA2 = '0; INBUS_RE2 = 1'b0; INBUS_ADDR2 = '0;
  endtask

  task automatic wr(input int side, input logic [7:0] off, input logic [7:0] d);
    set_wr(side, off, d);
    step();
  endtask

  task automatic rd(input int side, input logic [7:0] off, input logic [7:0] exp,
                    input string name);
    set_rd(side, off, exp, name);
    step();
  endtask

  // Monitor: a read strobe sampled at a posedge yields data checked at the following negedge.
  initial begin
    logic p1, p2;
    logic [7:0] v;
    string n;
    forever begin
      @(posedge clk);
      p1 = INBUS_RE1;
      p2 = INBUS_RE2;
      @(negedge clk);
      if (p1) begin
        if (q1v.size() == 0) begin
          total_cnt++;
          $display("FAIL rd1_unexpected: got %02h with no expected value queued", INBUS_DATA1);
        end else begin
          v = q1v.pop_front(); n = q1n.pop_front();
          chk(n, INBUS_DATA1, v);
        end
      end
      if (p2) begin
        if (q2v.size() == 0) begin
          total_cnt++;
          $display("FAIL rd2_unexpected: got %02h with no expected value queued", INBUS_DATA2);
        end else begin
          v = q2v.pop_front(); n = q2n.pop_front();
          chk(n, INBUS_DATA2, v);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    chk("rst_data1", INBUS_DATA1, 8'h00);
    chk("rst_data2", INBUS_DATA2, 8'h00);
    chk("rst_irq1", {7'b0, IRQ1}, 8'h00);
    chk("rst_irq2", {7'b0, IRQ2}, 8'h00);
    rd(1, MB_STATUS, 8'h04, "rst_status1");
    rd(2, MB_STATUS, 8'h04, "rst_status2");
    rd(1, MB_CTRL, 8'h00, "rst_ctrl1");

    // Single byte 1->2, then an underflowing read.
    wr(1, MB_DATA, 8'hA5);
    rd(2, MB_STATUS, 8'h0D, "one_status2");
    rd(2, MB_DATA, 8'hA5, "one_data");
    rd(2, MB_DATA, 8'h00, "unf_data");
    rd(2, MB_STATUS, 8'h84, "unf_status2");
    wr(2, MB_STATUS, 8'h80);
    rd(2, MB_STATUS, 8'h04, "unf_cleared");

    // Overflow on the fifth write.
    for (int i = 1; i <= 4; i++) wr(1, MB_DATA, 8'(i));
    rd(1, MB_STATUS, 8'h02, "full_status1");
    wr(1, MB_DATA, 8'h05);
    rd(1, MB_STATUS, 8'h42, "ovf_status1");
    for (int i = 1; i <= 4; i++) rd(2, MB_DATA, 8'(i), "fill_order");
    rd(2, MB_STATUS, 8'h04, "drained_status2");
    wr(1, MB_STATUS, 8'h40);
    rd(1, MB_STATUS, 8'h04, "ovf_cleared");

    // Push into a full FIFO while it is being popped: push dropped, pop proceeds.
    for (int i = 1; i <= 4; i++) wr(1, MB_DATA, 8'h20 + 8'(i));
    set_wr(1, MB_DATA, 8'h25);
    set_rd(2, MB_DATA, 8'h21, "full_pop_data");
    step();
    rd(1, MB_STATUS, 8'h40, "full_push_ovf");
    wr(1, MB_STATUS, 8'h40);
    rd(2, MB_DATA, 8'h22, "full_pop_rest");
    rd(2, MB_DATA, 8'h23, "full_pop_rest");
    rd(2, MB_DATA, 8'h24, "full_pop_rest");
    rd(2, MB_STATUS, 8'h04, "full_pop_status2");

    // Simultaneous push and pop with two entries held.
    wr(1, MB_DATA, 8'h31);
    wr(1, MB_DATA, 8'h32);
    set_wr(1, MB_DATA, 8'h77);
    set_rd(2, MB_DATA, 8'h31, "pushpop_oldest");
    step();
    rd(2, MB_STATUS, 8'h15, "pushpop_count2");
    rd(2, MB_DATA, 8'h32, "pushpop_next");
    rd(2, MB_DATA, 8'h77, "pushpop_last");

    // Push to an empty FIFO with a same-cycle pop: the pop underflows, the push lands.
    set_wr(1, MB_DATA, 8'h55);
    set_rd(2, MB_DATA, 8'h00, "empty_pushpop_data");
    step();
    rd(2, MB_STATUS, 8'h8D, "empty_pushpop_status");
    rd(2, MB_DATA, 8'h55, "empty_pushpop_stored");
    wr(2, MB_STATUS, 8'h80);
    rd(2, MB_STATUS, 8'h04, "unf_cleared2");

    // Underflow and W1C in the same cycle: the flag stays set.
    set_rd(2, MB_DATA, 8'h00, "setwins_data");
    set_wr(2, MB_STATUS, 8'h80);
    step();
    rd(2, MB_STATUS, 8'h84, "setwins_status");
    wr(2, MB_STATUS, 8'h80);
    rd(2, MB_STATUS, 8'h04, "setwins_cleared");

    // RX interrupt on side 2.
    wr(2, MB_CTRL, 8'hFD);
    rd(2, MB_CTRL, 8'h01, "ctrl2_readback");
    chk("irq2_idle", {7'b0, IRQ2}, 8'h00);
    wr(1, MB_DATA, 8'h99);
    chk("irq2_write_edge", {7'b0, IRQ2}, 8'h00);
    step();
    chk("irq2_rise", {7'b0, IRQ2}, 8'h01);
    chk("irq1_quiet", {7'b0, IRQ1}, 8'h00);
    rd(2, MB_DATA, 8'h99, "irq_data");
    chk("irq2_pop_edge", {7'b0, IRQ2}, 8'h01);
    step();
    chk("irq2_fall", {7'b0, IRQ2}, 8'h00);
    wr(2, MB_CTRL, 8'h00);

    // TX-empty interrupt on side 1.
    wr(1, MB_CTRL, 8'h02);
    step();
    chk("irq1_txempty", {7'b0, IRQ1}, 8'h01);
    wr(1, MB_CTRL, 8'h00);
    step();
    chk("irq1_txempty_off", {7'b0, IRQ1}, 8'h00);

    // Asynchronous reset with data in flight.
    wr(2, MB_DATA, 8'hC1);
    wr(2, MB_DATA, 8'hC2);
    wr(2, MB_DATA, 8'hC3);
    wr(1, MB_CTRL, 8'h01);
    step();
    chk("irq1_pre_reset", {7'b0, IRQ1}, 8'h01);
    rd(1, MB_STATUS, 8'h1D, "pre_reset_status1");
    step();
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_irq1", {7'b0, IRQ1}, 8'h00);
    chk("async_rst_data1", INBUS_DATA1, 8'h00);
    chk("async_rst_data2", INBUS_DATA2, 8'h00);
    #1 reset_n = 1'b1;
    rd(1, MB_STATUS, 8'h04, "post_reset_status1");
    rd(2, MB_STATUS, 8'h04, "post_reset_status2");
    rd(1, MB_CTRL, 8'h00, "post_reset_ctrl1");
    rd(1, MB_DATA, 8'h00, "post_reset_discarded");
    wr(1, MB_STATUS, 8'h80);
    chk("post_reset_irq1", {7'b0, IRQ1}, 8'h00);

    // Pointer wraparound: 3*DEPTH bytes through the 1->2 FIFO.
    for (int i = 0; i < 12; i++) begin
      wr(1, MB_DATA, 8'h10 + 8'(i));
      rd(2, MB_DATA, 8'h10 + 8'(i), "wrap_data");
    end
    rd(1, MB_STATUS, 8'h04, "wrap_status1");
    rd(2, MB_STATUS, 8'h04, "wrap_status2");

    step();
    step();
    chk("q1_drained", 8'(q1v.size()), 8'h00);
    chk("q2_drained", 8'(q2v.size()), 8'h00);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
